// File: rtl/avg_pool.sv
// 2x2 average-pooling element: registered mean of four unsigned pixels, 1-cycle latency,
// one window per clock with no backpressure. Define AVGPOOL_ROUND_EN for round-half-up instead of floor.
module avg_pool #(
  parameter int DATA_W = 4,
  parameter int SUM_W  = DATA_W + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] pixel1,
  input  logic [DATA_W-1:0] pixel2,
  input  logic [DATA_W-1:0] pixel3,
  input  logic [DATA_W-1:0] pixel4,
  output logic [DATA_W-1:0] average,
  output logic              out_valid
);

  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_adj;
  logic [DATA_W-1:0] mean;

  // Four DATA_W operands need two extra bits, so the sum can never wrap.
  assign sum = {{(SUM_W-DATA_W){1'b0}}, pixel1}
             + {{(SUM_W-DATA_W){1'b0}}, pixel2}
             + {{(SUM_W-DATA_W){1'b0}}, pixel3}
             + {{(SUM_W-DATA_W){1'b0}}, pixel4};

`ifdef AVGPOOL_ROUND_EN
  // Adding half an LSB before the shift rounds half-up; all-ones input still maps to all-ones.
  assign sum_adj = sum + SUM_W'(2);
`else
  assign sum_adj = sum;
`endif

  assign mean = sum_adj[DATA_W+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      average   <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        average <= mean;
      end
    end
  end

endmodule

// File: tb/tb_avg_pool.sv
// Directed bench for avg_pool with a queue-based scoreboard; expectations follow the active rounding build.
module tb_avg_pool;

  localparam int DATA_W = 4;
  localparam int SUM_W  = DATA_W + 2;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [DATA_W-1:0] pixel1, pixel2, pixel3, pixel4;
  logic [DATA_W-1:0] average;
  logic              out_valid;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DATA_W:0] sb_q[$];
  logic [DATA_W-1:0] model_avg;

  avg_pool #(.DATA_W(DATA_W), .SUM_W(SUM_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .pixel1   (pixel1),
    .pixel2   (pixel2),
    .pixel3   (pixel3),
    .pixel4   (pixel4),
    .average  (average),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] ref_mean(input int a, input int b, input int c, input int d);
    int s;
    s = a + b + c + d;
`ifdef AVGPOOL_ROUND_EN
    return DATA_W'((s + 2) / 4);
`else
    return DATA_W'(s / 4);
`endif
  endfunction

  task automatic chk(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of stimulus, predict the registered result, then compare one edge later.
  task automatic step(input string tag, input logic r, input logic v,
                      input int a, input int b, input int c, input int d);
    logic [DATA_W:0] exp;
    rst = r; in_valid = v;
    pixel1 = DATA_W'(a); pixel2 = DATA_W'(b); pixel3 = DATA_W'(c); pixel4 = DATA_W'(d);
    if (r) model_avg = '0;
    else if (v) model_avg = ref_mean(a, b, c, d);
    exp = {(!r && v), model_avg};
    sb_q.push_back(exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $error("FAIL %s: scoreboard empty got %0h expected entry", tag, average);
    end else begin
      exp = sb_q.pop_front();
      chk({tag, ".avg"}, average, exp[DATA_W-1:0]);
      chk({tag, ".vld"}, DATA_W'(out_valid), DATA_W'(exp[DATA_W]));
    end
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0;
    pixel1 = '0; pixel2 = '0; pixel3 = '0; pixel4 = '0;
    model_avg = '0;
    @(posedge clk);
    #1;

    // Reset wins over a valid all-ones window for two edges.
    step("rst0", 1'b1, 1'b1, 15, 15, 15, 15);
    step("rst1", 1'b1, 1'b1, 15, 15, 15, 15);
    chk("rst_const", average, 4'h0);
    step("rst_rel", 1'b0, 1'b1, 15, 15, 15, 15);
    chk("rst_rel_const", average, 4'hF);

    step("basic", 1'b0, 1'b1, 4, 3, 2, 1);
`ifdef AVGPOOL_ROUND_EN
    chk("basic_const", average, 4'h3);
`else
    chk("basic_const", average, 4'h2);
`endif

    step("b2b_a", 1'b0, 1'b1, 4, 3, 2, 1);
    step("b2b_b", 1'b0, 1'b1, 7, 8, 9, 10);
`ifdef AVGPOOL_ROUND_EN
    chk("b2b_const", average, 4'h9);
`else
    chk("b2b_const", average, 4'h8);
`endif

    step("zeros", 1'b0, 1'b1, 0, 0, 0, 0);
    chk("zeros_const", average, 4'h0);
    step("ones", 1'b0, 1'b1, 15, 15, 15, 15);
    chk("ones_const", average, 4'hF);
    step("fffe", 1'b0, 1'b1, 15, 15, 15, 14);
`ifdef AVGPOOL_ROUND_EN
    chk("fffe_const", average, 4'hF);
`else
    chk("fffe_const", average, 4'hE);
`endif

    // Hold: average must stay at the last accepted window while pixels wander.
    step("hold_ld", 1'b0, 1'b1, 8, 8, 8, 8);
    step("hold0", 1'b0, 1'b0, 1, 2, 3, 4);
    step("hold1", 1'b0, 1'b0, 15, 0, 15, 0);
    step("hold2", 1'b0, 1'b0, 5, 9, 13, 2);
    chk("hold_const", average, 4'h8);

    // Reset coincident with a valid window discards it.
    step("mid_pre", 1'b0, 1'b1, 12, 12, 12, 12);
    step("mid_rst", 1'b1, 1'b1, 7, 8, 9, 10);
    chk("mid_rst_const", average, 4'h0);
    step("mid_idle", 1'b0, 1'b0, 7, 8, 9, 10);

    // Random back-to-back and gapped traffic.
    for (int i = 0; i < 40; i++) begin
      step("rand", 1'b0, ($urandom_range(0, 3) != 0),
           $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), $urandom_range(0, 15));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
